// File: rtl/instr_sequencer_if.sv
// Fetch/timing bus between the instruction sequencer and its memory/control neighbours.
// master: the sequencer itself; slave: memory and control logic driving it.
interface instr_sequencer_if #(
  parameter int IR_W = 16,
  parameter int SC_W = 4
);
  logic [IR_W-1:0]        mem_data;
  logic                   mem_ready;
  logic                   sc_clr;
  logic                   mem_rd;
  logic [2:0]             cdp;
  logic                   i_bit;
  logic [IR_W-5:0]        addr;
  logic [(1<<SC_W)-1:0]   t;
  logic                   seq_err;
  logic                   halted;

  modport master (
    input  mem_data, mem_ready, sc_clr,
    output mem_rd, cdp, i_bit, addr, t, seq_err, halted
  );

  modport slave (
    output mem_data, mem_ready, sc_clr,
    input  mem_rd, cdp, i_bit, addr, t, seq_err, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction register plus sequence counter with one-hot T0..T15 timing; stalls T1 until memory is ready.
// Optional halt detection on HLT (16'h7001) when HALT_DETECT_EN is defined.
module instr_sequencer #(
  parameter int IR_W = 16,
  parameter int SC_W = 4
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);

  localparam int T_W = 1 << SC_W;
  localparam logic [SC_W-1:0] SC_ZERO  = '0;
  localparam logic [SC_W-1:0] SC_FETCH = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LAST  = {SC_W{1'b1}};
  localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);
  localparam logic [T_W-1:0]  T_ONE    = T_W'(1);

  logic [IR_W-1:0] ir_q, ir_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            seq_err_q, seq_err_d;
  logic            stall;
  logic            ir_load;
  logic            sc_freeze;

`ifdef HALT_DETECT_EN
  localparam logic [SC_W-1:0] SC_EXEC  = SC_W'(3);
  localparam logic [IR_W-1:0] HLT_INSTR = IR_W'(16'h7001);

  logic halted_q, halted_d;
  logic halt_hit;

  // The halting edge itself must also freeze SC so t stays at T3.
  always_comb begin
    halt_hit  = (ir_q == HLT_INSTR) && (sc_q == SC_EXEC) && !bus.sc_clr;
    sc_freeze = halted_q || halt_hit;
    halted_d  = halted_q || halt_hit;
  end
`else
  always_comb begin
    sc_freeze = 1'b0;
  end
`endif

  always_comb begin
    stall   = (sc_q == SC_FETCH) && !bus.mem_ready;
    ir_load = (sc_q == SC_FETCH) && bus.mem_ready && !bus.sc_clr;
`ifdef HALT_DETECT_EN
    ir_load = ir_load && !halted_q;
`endif
  end

  always_comb begin
    ir_d      = ir_q;
    sc_d      = sc_q;
    seq_err_d = seq_err_q;

    if (ir_load) begin
      ir_d = bus.mem_data;
    end

    // sc_clr outranks halt and stall; a wrap without it is a sequencing fault.
    if (bus.sc_clr) begin
      sc_d = SC_ZERO;
    end else if (sc_freeze) begin
      sc_d = sc_q;
    end else if (stall) begin
      sc_d = sc_q;
    end else if (sc_q == SC_LAST) begin
      sc_d      = SC_ZERO;
      seq_err_d = 1'b1;
    end else begin
      sc_d = sc_q + SC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      sc_q      <= SC_ZERO;
      seq_err_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      sc_q      <= sc_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign bus.halted = halted_q;
  assign bus.mem_rd = (sc_q == SC_FETCH) && !halted_q;
`else
  assign bus.halted = 1'b0;
  assign bus.mem_rd = (sc_q == SC_FETCH);
`endif

  assign bus.cdp     = ir_q[IR_W-2:IR_W-4];
  assign bus.i_bit   = ir_q[IR_W-1];
  assign bus.addr    = ir_q[IR_W-5:0];
  assign bus.t       = T_ONE << sc_q;
  assign bus.seq_err = seq_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_instr_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  instr_sequencer_if bus_if ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_t;
    n_checks = 0;
    n_errors = 0;
    rst                = 1'b1;
    bus_if.mem_data    = 16'h0000;
    bus_if.mem_ready   = 1'b0;
    bus_if.sc_clr      = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_t",       32'(bus_if.t),       32'h0001);
    chk("rst_cdp",     32'(bus_if.cdp),     32'h0);
    chk("rst_ibit",    32'(bus_if.i_bit),   32'h0);
    chk("rst_addr",    32'(bus_if.addr),    32'h000);
    chk("rst_mem_rd",  32'(bus_if.mem_rd),  32'h0);
    chk("rst_seq_err", 32'(bus_if.seq_err), 32'h0);
    chk("rst_halted",  32'(bus_if.halted),  32'h0);

    // Release reset -> T1 with read strobe
    rst = 1'b0;
    cyc();
    chk("t1_t",      32'(bus_if.t),      32'h0002);
    chk("t1_mem_rd", 32'(bus_if.mem_rd), 32'h1);

    // Fetch B123 with memory ready
    bus_if.mem_data  = 16'hB123;
    bus_if.mem_ready = 1'b1;
    cyc();
    chk("f1_t",      32'(bus_if.t),      32'h0004);
    chk("f1_cdp",    32'(bus_if.cdp),    32'h3);
    chk("f1_ibit",   32'(bus_if.i_bit),  32'h1);
    chk("f1_addr",   32'(bus_if.addr),   32'h123);
    chk("f1_mem_rd", 32'(bus_if.mem_rd), 32'h0);
    bus_if.mem_ready = 1'b0;
    cyc();
    chk("f1_t3", 32'(bus_if.t), 32'h0008);
    bus_if.sc_clr = 1'b1;
    cyc();
    chk("f1_clr_t", 32'(bus_if.t), 32'h0001);
    bus_if.sc_clr = 1'b0;

    // Stalled fetch of 2005: three not-ready T1 cycles, ready on the fourth
    bus_if.mem_data = 16'h2005;
    cyc();
    chk("st_t_1",   32'(bus_if.t),      32'h0002);
    chk("st_rd_1",  32'(bus_if.mem_rd), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk($sformatf("st_t_%0d", i),  32'(bus_if.t),      32'h0002);
      chk($sformatf("st_rd_%0d", i), 32'(bus_if.mem_rd), 32'h1);
      chk($sformatf("st_ir_%0d", i), 32'(bus_if.cdp),    32'h3);
    end
    bus_if.mem_ready = 1'b1;
    cyc();
    chk("st_t2_t",    32'(bus_if.t),     32'h0004);
    chk("st_t2_cdp",  32'(bus_if.cdp),   32'h2);
    chk("st_t2_ibit", 32'(bus_if.i_bit), 32'h0);
    chk("st_t2_addr", 32'(bus_if.addr),  32'h005);
    bus_if.mem_ready = 1'b0;
    bus_if.sc_clr    = 1'b1;
    cyc();
    chk("st_clr_t", 32'(bus_if.t), 32'h0001);
    bus_if.sc_clr = 1'b0;

    // Fetch abort: sc_clr at T1, first without ready then with ready
    bus_if.mem_data = 16'hFFFF;
    cyc();
    chk("ab1_t1", 32'(bus_if.t), 32'h0002);
    bus_if.sc_clr = 1'b1;
    cyc();
    chk("ab1_t",    32'(bus_if.t),      32'h0001);
    chk("ab1_cdp",  32'(bus_if.cdp),    32'h2);
    chk("ab1_addr", 32'(bus_if.addr),   32'h005);
    chk("ab1_rd",   32'(bus_if.mem_rd), 32'h0);
    bus_if.sc_clr = 1'b0;
    cyc();
    chk("ab2_t1", 32'(bus_if.t), 32'h0002);
    bus_if.sc_clr    = 1'b1;
    bus_if.mem_ready = 1'b1;
    cyc();
    chk("ab2_t",    32'(bus_if.t),     32'h0001);
    chk("ab2_cdp",  32'(bus_if.cdp),   32'h2);
    chk("ab2_ibit", 32'(bus_if.i_bit), 32'h0);
    chk("ab2_addr", 32'(bus_if.addr),  32'h005);
    bus_if.sc_clr = 1'b0;

    // Full walk T0..T15, sc_clr at T15 must not set seq_err
    bus_if.mem_data = 16'h4321;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      exp_t = 16'h0001 << k;
      chk($sformatf("walk_t_%0d", k), 32'(bus_if.t), 32'(exp_t));
    end
    chk("walk_cdp",     32'(bus_if.cdp),     32'h4);
    chk("walk_addr",    32'(bus_if.addr),    32'h321);
    chk("walk_seq_err", 32'(bus_if.seq_err), 32'h0);
    bus_if.sc_clr = 1'b1;
    cyc();
    chk("clr15_t",       32'(bus_if.t),       32'h0001);
    chk("clr15_seq_err", 32'(bus_if.seq_err), 32'h0);
    bus_if.sc_clr = 1'b0;

    // Second walk without sc_clr: wraps and sets sticky seq_err
    for (int k = 1; k <= 15; k++) begin
      cyc();
    end
    chk("wrap_pre_t",   32'(bus_if.t),       32'h8000);
    chk("wrap_pre_err", 32'(bus_if.seq_err), 32'h0);
    cyc();
    chk("wrap_t",   32'(bus_if.t),       32'h0001);
    chk("wrap_err", 32'(bus_if.seq_err), 32'h1);
    cyc(); cyc();
    chk("wrap_t2",    32'(bus_if.t),       32'h0004);
    chk("wrap_err_2", 32'(bus_if.seq_err), 32'h1);
    bus_if.sc_clr = 1'b1;
    cyc();
    chk("wrap_err_clr", 32'(bus_if.seq_err), 32'h1);
    bus_if.sc_clr = 1'b0;
    rst = 1'b1;
    cyc();
    chk("wrap_err_rst", 32'(bus_if.seq_err), 32'h0);
    chk("wrap_cdp_rst", 32'(bus_if.cdp),     32'h0);
    chk("wrap_t_rst",   32'(bus_if.t),       32'h0001);

    // HLT fetch
    rst = 1'b0;
    bus_if.mem_data  = 16'h7001;
    bus_if.mem_ready = 1'b1;
    cyc();
    chk("hlt_t1", 32'(bus_if.t), 32'h0002);
    cyc();
    chk("hlt_cdp",  32'(bus_if.cdp),  32'h7);
    chk("hlt_addr", 32'(bus_if.addr), 32'h001);
    cyc();
    chk("hlt_t3",     32'(bus_if.t),      32'h0008);
    chk("hlt_t3_hlt", 32'(bus_if.halted), 32'h0);
    cyc();
`ifdef HALT_DETECT_EN
    chk("hlt_halted", 32'(bus_if.halted), 32'h1);
    chk("hlt_frz_t",  32'(bus_if.t),      32'h0008);
    chk("hlt_frz_rd", 32'(bus_if.mem_rd), 32'h0);
    cyc();
    chk("hlt_frz_t2", 32'(bus_if.t), 32'h0008);
    bus_if.sc_clr = 1'b1;
    cyc();
    chk("hlt_clr_t",   32'(bus_if.t),      32'h0001);
    chk("hlt_clr_hlt", 32'(bus_if.halted), 32'h1);
    bus_if.sc_clr = 1'b0;
    cyc();
    chk("hlt_hold_t",   32'(bus_if.t),      32'h0001);
    chk("hlt_hold_rd",  32'(bus_if.mem_rd), 32'h0);
    chk("hlt_hold_hlt", 32'(bus_if.halted), 32'h1);
    rst = 1'b1;
    cyc();
    chk("hlt_rst_hlt", 32'(bus_if.halted), 32'h0);
    chk("hlt_rst_t",   32'(bus_if.t),      32'h0001);
`else
    chk("nohlt_halted", 32'(bus_if.halted), 32'h0);
    chk("nohlt_t4",     32'(bus_if.t),      32'h0010);
    cyc();
    chk("nohlt_t5", 32'(bus_if.t), 32'h0020);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
